k005297_mskreg_sr: RTL
======================

Name: k005297_mskreg_sr

Overview:
Mask register shift stage, directly downstream of the mask-load timer.
- Holds the next 16-bit bootloop mask word written from the data bus.
- Parallel-loads that word into a shift register when the timer asserts the load pulse.
- Shifts one mask bit out per minor-loop bit slot (ROT20 phase), giving o_MSK_BIT.
- o_MSK_BIT gates bubble write/read of each minor loop and raises a refill request to the DMA/CPU side.

Parameters:
MSK_W, 16, mask word width (shift register and holding register width)
CNT_W, 5, width of the shift counter (must hold MSK_W)

Ports:
i_MCLK  in  1  master clock; the only clock
i_RST_n  in  1  asynchronous active-low reset
i_CLK2M_PCEN_n  in  1  2 MHz clock enable, active low; all state updates are gated by it
i_ROT20_n  in  20  one-cold rotation phase (bit k low = slot k)
i_4BEN_n  in  1  low = 4-bit bubble mode (4 shifts per rotation), high = 2 shifts per rotation
i_ACC_ACT_n  in  1  low = bubble access active
i_MSKREG_SR_LD  in  1  load pulse from the mask-load timer
i_MSKHOLD_WR  in  1  one-enable-cycle write strobe for the holding register
i_DBUS  in  MSK_W  mask word to store
o_MSK_BIT  out  1  current mask bit; 1 = loop good/enabled
o_MSKHOLD_EMPTY  out  1  refill request: holding register consumed
o_MSK_UNDERRUN  out  1  sticky: load pulse arrived with empty holding register
o_MSK_EXHAUST  out  1  all MSK_W bits shifted since last load
o_MSK_ZCNT  out  CNT_W  masked-bit count (present only with the optional feature; otherwise tied 0)

Behaviour:
- Async reset values:
  - hold = all-ones, sr = all-ones, shift_cnt = 0
  - o_MSK_BIT = 0, o_MSKHOLD_EMPTY = 1, o_MSK_UNDERRUN = 0, o_MSK_EXHAUST = 0, o_MSK_ZCNT = 0
- Every registered update below occurs only on i_MCLK edges where i_CLK2M_PCEN_n = 0.
- shift_en = ~i_ROT20_n[0] | ~i_ROT20_n[5] | (~i_4BEN_n & (~i_ROT20_n[10] | ~i_ROT20_n[15])).
- Idle (i_ACC_ACT_n = 1), synchronous clear:
  - sr = all-ones, shift_cnt = 0, o_MSK_EXHAUST = 0, o_MSK_UNDERRUN = 0, o_MSK_BIT = 0
  - hold and o_MSKHOLD_EMPTY keep their values, so the word can be prefetched before access.
- Holding register:
  - i_MSKHOLD_WR: hold <= i_DBUS; o_MSKHOLD_EMPTY <= 0.
  - Load pulse: o_MSKHOLD_EMPTY <= 1.
  - Write and load in the same enable cycle: sr takes the old hold value, hold takes i_DBUS, EMPTY ends 0 (write wins).
- Active (i_ACC_ACT_n = 0), priority load > shift:
  - Load (i_MSKREG_SR_LD = 1):
    - sr <= hold if EMPTY = 0; else sr <= all-ones and o_MSK_UNDERRUN <= 1 (sticky until idle)
    - shift_cnt <= 0; o_MSK_EXHAUST <= 0
  - Shift (shift_en = 1 and not load):
    - o_MSK_BIT <= sr[MSK_W-1]
    - sr <= {sr[MSK_W-2:0], 1'b1}
    - shift_cnt increments
    - when shift_cnt reaches MSK_W-1 before the increment, o_MSK_EXHAUST <= 1 and shift_cnt saturates at MSK_W
    - further shifts present 1 (loop enabled) and keep o_MSK_EXHAUST at 1
  - Load and shift_en coincide: load only; no bit is output that cycle, and o_MSK_BIT holds.
- Latency:
  - o_MSK_BIT reflects sr MSB one enable cycle after the shift slot.
  - The first bit of a loaded word appears at the first shift slot after the load cycle.
- Reset asserted mid-operation aborts immediately to the reset values above.

Optional Feature:
K005297_MSK_ZCNT_EN
- Defined:
  - o_MSK_ZCNT counts mask bits shifted out as 0 since the last load; it is cleared on load and in idle.
  - It saturates at MSK_W.
- Undefined:
  - o_MSK_ZCNT is constant 0.
  - No counter logic is synthesised.

Decomposition:
- Shared package k005297_pkg holds:
  - MSK_W and the ROT20 slot index constants (SLOT_A = 0, SLOT_B = 5, SLOT_C = 10, SLOT_D = 15)
  - MSK_ALL_ONES constant
- One sub-module is natural: k005297_mskhold, the holding register plus EMPTY flag and write/load arbitration.
- Shift register, counter, and flags stay in the top module.

Test Plan:
1. Reset, write 0xA5F0, idle→active, pulse SR_LD, 2-bit mode -> EMPTY 1 after load; o_MSK_BIT sequence at slots 0, 5 = 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0; EXHAUST 1 after the 16th shift; later shifts output 1.
2. 4-bit mode (i_4BEN_n = 0), word 0x8001 -> 4 shifts per rotation at slots 0, 5, 10, 15; bits 1, then 14 zeros, then 1; EXHAUST after 4 rotations.
3. SR_LD with EMPTY = 1 -> sr all-ones; UNDERRUN 1 and stays set until i_ACC_ACT_n = 1; all output bits 1.
4. i_MSKHOLD_WR of 0x1234 in the same enable cycle as SR_LD with hold = 0xFFFF -> sr shifts out 0xFFFF; hold = 0x1234; EMPTY = 0.
5. SR_LD coincident with slot 0 -> no shift that cycle; o_MSK_BIT unchanged; first new bit at slot 5. Also deassert i_RST_n mid-word -> all reset values immediately, without waiting for a clock.
6. With K005297_MSK_ZCNT_EN, word 0x0F0F -> o_MSK_ZCNT reaches 8 after 16 shifts and clears on the next load; without the macro it stays 0.

Source files
------------

// File: rtl/k005297_pkg.sv
// Shared constants and types for the K005297 mask register shift stage.
package k005297_pkg;

    localparam int MSK_W = 16;
    localparam int CNT_W = 5;

    localparam int SLOT_A = 0;
    localparam int SLOT_B = 5;
    localparam int SLOT_C = 10;
    localparam int SLOT_D = 15;

    localparam logic [MSK_W-1:0] MSK_ALL_ONES = '1;

    // Operation selected for the shift register in one enable cycle.
    typedef enum logic [1:0] {
        SR_HOLD  = 2'd0,
        SR_IDLE  = 2'd1,
        SR_LOAD  = 2'd2,
        SR_SHIFT = 2'd3
    } srOp_e;

    // Two shift slots per rotation in 2-bit mode, four in 4-bit mode.
    function automatic logic shiftEnable(input logic [19:0] rot20_n, input logic ben4_n);
        return ~rot20_n[SLOT_A] | ~rot20_n[SLOT_B] |
               (~ben4_n & (~rot20_n[SLOT_C] | ~rot20_n[SLOT_D]));
    endfunction

endpackage

// File: rtl/k005297_mskreg_sr_if.sv
// Data-bus side of the mask register: word write, load pulse and refill request.
interface k005297_mskreg_sr_if #(
    parameter int MSK_W = k005297_pkg::MSK_W
);
    logic [MSK_W-1:0] i_DBUS;
    logic             i_MSKHOLD_WR;
    logic             i_MSKREG_SR_LD;
    logic             o_MSKHOLD_EMPTY;

    modport master (
        output i_DBUS,
        output i_MSKHOLD_WR,
        output i_MSKREG_SR_LD,
        input  o_MSKHOLD_EMPTY
    );

    modport slave (
        input  i_DBUS,
        input  i_MSKHOLD_WR,
        input  i_MSKREG_SR_LD,
        output o_MSKHOLD_EMPTY
    );
endinterface

// File: rtl/k005297_mskreg_sr_mskhold.sv
// Holding register for the next mask word plus its EMPTY flag.
// A write in the same cycle as a load wins: the old word goes to the
// shift register while the new word is kept and EMPTY stays clear.
module k005297_mskhold
    import k005297_pkg::*;
#(
    parameter int MSK_W = k005297_pkg::MSK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic             ld_i,
    input  logic [MSK_W-1:0] data_i,
    output logic [MSK_W-1:0] hold_o,
    output logic             empty_o
);

    logic [MSK_W-1:0] hold_q, hold_d;
    logic             empty_q, empty_d;

    // Write/load arbitration for the holding word and its refill flag.
    always_comb begin
        hold_d  = hold_q;
        empty_d = empty_q;
        if (en_i) begin
            if (ld_i) begin
                empty_d = 1'b1;
            end
            if (wr_i) begin
                hold_d  = data_i;
                empty_d = 1'b0;
            end
        end
    end

    // Holding register state; comes up empty with an all-ones word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '1;
            empty_q <= 1'b1;
        end else begin
            hold_q  <= hold_d;
            empty_q <= empty_d;
        end
    end

    assign hold_o  = hold_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/k005297_mskreg_sr.sv
// Mask register shift stage: shifts one bootloop mask bit per minor-loop slot.
// Optional masked-bit counter on o_MSK_ZCNT is built when K005297_MSK_ZCNT_EN
// is defined; otherwise the port is tied to zero.
module k005297_mskreg_sr
    import k005297_pkg::*;
#(
    parameter int MSK_W = k005297_pkg::MSK_W,
    parameter int CNT_W = k005297_pkg::CNT_W
) (
    input  logic             i_MCLK,
    input  logic             i_RST_n,
    input  logic             i_CLK2M_PCEN_n,
    input  logic [19:0]      i_ROT20_n,
    input  logic             i_4BEN_n,
    input  logic             i_ACC_ACT_n,
    k005297_mskreg_sr_if.slave bus,
    output logic             o_MSK_BIT,
    output logic             o_MSK_UNDERRUN,
    output logic             o_MSK_EXHAUST,
    output logic [CNT_W-1:0] o_MSK_ZCNT
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSK_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MSK_W);

    logic             enable;
    logic             shiftEn;
    logic             loadActive;
    srOp_e            op;

    logic [MSK_W-1:0] holdWord;
    logic             holdEmpty;

    logic [MSK_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             underrun_q, underrun_d;
    logic             exhaust_q, exhaust_d;

    assign enable     = ~i_CLK2M_PCEN_n;
    assign shiftEn    = shiftEnable(i_ROT20_n, i_4BEN_n);
    assign loadActive = ~i_ACC_ACT_n & bus.i_MSKREG_SR_LD;

    // Loads only consume the held word while an access is in progress,
    // so a prefetched word survives the idle period.
    k005297_mskhold #(
        .MSK_W (MSK_W)
    ) u_mskhold (
        .clk     (i_MCLK),
        .rst_n   (i_RST_n),
        .en_i    (enable),
        .wr_i    (bus.i_MSKHOLD_WR),
        .ld_i    (loadActive),
        .data_i  (bus.i_DBUS),
        .hold_o  (holdWord),
        .empty_o (holdEmpty)
    );

    assign bus.o_MSKHOLD_EMPTY = holdEmpty;

    // Pick this cycle's operation: idle clear, then load over shift.
    always_comb begin
        op = SR_HOLD;
        if (enable) begin
            if (i_ACC_ACT_n) begin
                op = SR_IDLE;
            end else if (bus.i_MSKREG_SR_LD) begin
                op = SR_LOAD;
            end else if (shiftEn) begin
                op = SR_SHIFT;
            end
        end
    end

    // Next state of shift register, shift counter and status flags.
    always_comb begin
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        underrun_d = underrun_q;
        exhaust_d  = exhaust_q;
        case (op)
            SR_IDLE: begin
                sr_d       = '1;
                cnt_d      = '0;
                bit_d      = 1'b0;
                underrun_d = 1'b0;
                exhaust_d  = 1'b0;
            end
            SR_LOAD: begin
                if (holdEmpty) begin
                    sr_d       = '1;
                    underrun_d = 1'b1;
                end else begin
                    sr_d = holdWord;
                end
                cnt_d     = '0;
                exhaust_d = 1'b0;
            end
            SR_SHIFT: begin
                bit_d = sr_q[MSK_W-1];
                sr_d  = {sr_q[MSK_W-2:0], 1'b1};
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = CNT_FULL;
                    exhaust_d = 1'b1;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Shift stage registers with asynchronous abort to reset values.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            sr_q       <= '1;
            cnt_q      <= '0;
            bit_q      <= 1'b0;
            underrun_q <= 1'b0;
            exhaust_q  <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            underrun_q <= underrun_d;
            exhaust_q  <= exhaust_d;
        end
    end

    assign o_MSK_BIT      = bit_q;
    assign o_MSK_UNDERRUN = underrun_q;
    assign o_MSK_EXHAUST  = exhaust_q;

`ifdef K005297_MSK_ZCNT_EN
    logic [CNT_W-1:0] zcnt_q, zcnt_d;

    // Count zero mask bits shifted out since the last load, saturating.
    always_comb begin
        zcnt_d = zcnt_q;
        case (op)
            SR_IDLE, SR_LOAD: zcnt_d = '0;
            SR_SHIFT: begin
                if (!sr_q[MSK_W-1] && (zcnt_q < CNT_FULL)) begin
                    zcnt_d = zcnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Masked-bit counter register.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            zcnt_q <= '0;
        end else begin
            zcnt_q <= zcnt_d;
        end
    end

    assign o_MSK_ZCNT = zcnt_q;
`else
    assign o_MSK_ZCNT = '0;
`endif

endmodule
